// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan multiplexer.
//   NUM_DIGITS : digits scanned per frame
//   SEG_OFF    : all segments dark (active-low)
//   AN_OFF     : all anodes deselected (active-low)
//   HEX_SEG    : hex nibble -> active-low segment pattern {g,f,e,d,c,b,a}
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // Entry n sits at HEX_SEG[n]; the concatenation lists F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment decoder.
//   nibble_i : hex value 0..F
//   seg_o    : active-low segments, seg_o[0]=a .. seg_o[6]=g
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a 4-digit common-anode display.
// A slot counter (DIV = CLK_FREQ/REFRESH_HZ cycles) steps a digit index 0..3;
// a new frame is captured by 'load' into a pending bank and promoted to the
// displayed (active) bank only at the frame boundary, so a frame never tears.
//   clk, rst     : clock, synchronous active-high reset
//   load         : one-cycle strobe capturing digits_in/dp_in/en_in
//   digits_in    : four hex nibbles, nibble k -> digit k (digit 0 = an[0])
//   dp_in, en_in : per-digit decimal point (1 = lit) and enable (0 = dark)
//   seg, dp, an  : registered active-low segment / point / anode drives
//   frame_done   : one-cycle pulse in the cycle after each frame boundary
// Build option: define SEG_SCAN_BLANK_EN to dark the anodes and decimal point
// for the first BLANK_CYCLES counts of every slot (anti-ghosting).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int             DIV     = CLK_FREQ / REFRESH_HZ;
  localparam int             CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [1:0]     IDX_MAX = 2'(NUM_DIGITS - 1);

  if (DIV < 2 || BLANK_CYCLES >= DIV) begin : g_bad_cfg
    $error("seg_scan_mux: need DIV >= 2 and BLANK_CYCLES < DIV");
  end

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [15:0]   pend_dig_q, act_dig_q;
  logic [3:0]    pend_dp_q, act_dp_q, pend_en_q, act_en_q;
  logic          pend_q;
  logic [6:0]    seg_q;
  logic          dp_q, fd_q;
  logic [3:0]    an_q;

  logic          boundary, blank, lit, dp_d;
  logic [3:0]    cur_nib, an_d;
  logic [6:0]    seg_d;

  seg_hex_decode u_dec (
    .nibble_i (cur_nib),
    .seg_o    (seg_d)
  );

  always_comb begin
    boundary = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
    cur_nib  = act_dig_q[idx_q*4 +: 4];
`ifdef SEG_SCAN_BLANK_EN
    blank    = int'(cnt_q) < BLANK_CYCLES;
`else
    blank    = 1'b0;
`endif
    lit      = act_en_q[idx_q] && !blank;
    an_d     = AN_OFF;
    if (lit) an_d[idx_q] = 1'b0;
    dp_d     = lit ? ~act_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      pend_q     <= 1'b0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
      fd_q       <= 1'b0;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_MAX) ? 2'd0 : idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      fd_q  <= boundary;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;

      // A load landing on the boundary bypasses the pending bank entirely.
      if (load && boundary) begin
        act_dig_q <= digits_in;
        act_dp_q  <= dp_in;
        act_en_q  <= en_in;
        pend_q    <= 1'b0;
      end else if (load) begin
        pend_dig_q <= digits_in;
        pend_dp_q  <= dp_in;
        pend_en_q  <= en_in;
        pend_q     <= 1'b1;
      end else if (boundary && pend_q) begin
        act_dig_q <= pend_dig_q;
        act_dp_q  <= pend_dp_q;
        act_en_q  <= pend_en_q;
        pend_q    <= 1'b0;
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed table-driven bench for seg_scan_mux with DIV=4,
// BLANK_CYCLES=1 (16-cycle frame). k counts clock edges since reset release;
// outputs seen after edge k reflect the scan state after edge k-1.
module tb_seg_scan_mux;

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, en_in;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [3:0]  an;

  int k = 0;
  int nvec = 0;
  int nerr = 0;

  seg_scan_mux #(.CLK_FREQ(40), .REFRESH_HZ(10), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
    logic        ld;
    logic [15:0] d;
    logic [3:0]  dpi;
    logic [3:0]  eni;
  } vec_t;

  localparam int NV = 27;
  vec_t v [NV];

  function automatic vec_t mk(int c, logic [3:0] a, logic [6:0] s, logic d, logic f,
                              logic l = 1'b0, logic [15:0] dg = 16'h0,
                              logic [3:0] dpi = 4'h0, logic [3:0] ei = 4'h0);
    vec_t r;
    r.cyc = c; r.an = a; r.seg = s; r.dp = d; r.fd = f;
    r.ld = l; r.d = dg; r.dpi = dpi; r.eni = ei;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at k=%0d: got %h, want %h", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    load = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a, input logic [6:0] s,
                         input logic d, input logic f);
    chk({tag, ".an"},  16'(an), 16'(a));
    chk({tag, ".seg"}, 16'(seg), 16'(s));
    chk({tag, ".dp"},  16'(dp), 16'(d));
    chk({tag, ".fd"},  16'(frame_done), 16'(f));
  endtask

  initial begin
    // frame 0: nothing loaded, all dark; load 1234 mid-frame
    v[0]  = mk(1,  4'hF, 7'h40, 1'b1, 1'b0);
    v[1]  = mk(2,  4'hF, 7'h40, 1'b1, 1'b0, 1'b1, 16'h1234, 4'b0001, 4'hF);
    v[2]  = mk(8,  4'hF, 7'h40, 1'b1, 1'b0);
    v[3]  = mk(16, 4'hF, 7'h40, 1'b1, 1'b1);
    // frame 1: 1234, dp on digit 0, first cycle of each slot blanked
    v[4]  = mk(17, BLK ? 4'hF : 4'hE, 7'h19, BLK ? 1'b1 : 1'b0, 1'b0);
    v[5]  = mk(18, 4'hE, 7'h19, 1'b0, 1'b0);
    v[6]  = mk(20, 4'hE, 7'h19, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0000, 4'b0101);
    v[7]  = mk(21, BLK ? 4'hF : 4'hD, 7'h30, 1'b1, 1'b0);
    v[8]  = mk(22, 4'hD, 7'h30, 1'b1, 1'b0);
    v[9]  = mk(26, 4'hB, 7'h24, 1'b1, 1'b0);
    v[10] = mk(29, BLK ? 4'hF : 4'h7, 7'h79, 1'b1, 1'b0);
    v[11] = mk(30, 4'h7, 7'h79, 1'b1, 1'b0);
    v[12] = mk(32, 4'h7, 7'h79, 1'b1, 1'b1);
    // frame 2: enable mask 0101; load 8888 in the boundary cycle
    v[13] = mk(34, 4'hE, 7'h19, 1'b1, 1'b0);
    v[14] = mk(38, 4'hF, 7'h30, 1'b1, 1'b0);
    v[15] = mk(42, 4'hB, 7'h24, 1'b1, 1'b0);
    v[16] = mk(46, 4'hF, 7'h79, 1'b1, 1'b0);
    v[17] = mk(47, 4'hF, 7'h79, 1'b1, 1'b0, 1'b1, 16'h8888, 4'b0000, 4'hF);
    v[18] = mk(48, 4'hF, 7'h79, 1'b1, 1'b1);
    // frame 3: coincident load shown immediately
    v[19] = mk(49, BLK ? 4'hF : 4'hE, 7'h00, 1'b1, 1'b0);
    v[20] = mk(50, 4'hE, 7'h00, 1'b1, 1'b0);
    // frame 4: still 8888 (no stale pending); two loads, last one wins
    v[21] = mk(66, 4'hE, 7'h00, 1'b1, 1'b0, 1'b1, 16'h1111, 4'b0000, 4'hF);
    v[22] = mk(70, 4'hD, 7'h00, 1'b1, 1'b0, 1'b1, 16'hFFFF, 4'b0000, 4'hF);
    v[23] = mk(74, 4'hB, 7'h00, 1'b1, 1'b0);
    // frame 5: FFFF
    v[24] = mk(82, 4'hE, 7'h0E, 1'b1, 1'b0);
    v[25] = mk(86, 4'hD, 7'h0E, 1'b1, 1'b0);
    v[26] = mk(90, 4'hB, 7'h0E, 1'b1, 1'b0);

    rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; en_in = '0;
    step();
    chk_all("rst1", 4'hF, 7'h7F, 1'b1, 1'b0);
    step();
    chk_all("rst2", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    k = 0;

    for (int i = 0; i < NV; i++) begin
      while (k < v[i].cyc) begin
        step();
        if (k >= 33 && k <= 48) chk("en_mask", 16'({an[3], an[1]}), 16'h3);
      end
      chk_all($sformatf("vec%0d", i), v[i].an, v[i].seg, v[i].dp, v[i].fd);
      if (v[i].ld) begin
        load = 1'b1; digits_in = v[i].d; dp_in = v[i].dpi; en_in = v[i].eni;
      end
    end

    // reset mid-slot 2, with a load in the same cycle that must be ignored
    step();
    rst = 1'b1; load = 1'b1; digits_in = 16'hFFFF; dp_in = 4'hF; en_in = 4'hF;
    step();
    chk_all("rst_mid", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    k = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      chk("post_rst_dark", 16'(an), 16'hF);
      if (c == 15 || c == 16 || c == 32)
        chk("post_rst_fd", 16'(frame_done), (c == 15) ? 16'h0 : 16'h1);
      if (c == 20) begin
        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0001; en_in = 4'hF;
      end
    end
    while (k < 34) step();
    chk_all("restart_s0", 4'hE, 7'h19, 1'b0, 1'b0);
    while (k < 46) step();
    chk_all("restart_s3", 4'h7, 7'h79, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
